fixed_point_accumulator: RTL and testbench

Sequential accumulate-and-normalize stage that sits directly downstream of `fixed_point_mult`. It consumes a stream of 32-bit sign-magnitude products (24 fractional bits) and sums exactly `NUM_TERMS` of them, forming a dot product. It then rounds and saturates the sum back to the 16-bit sign-magnitude operand format (12 fractional bits) used at the multiplier inputs, and presents it on a valid/ready output.

---
 rtl/fixed_point_accumulator.sv | 91 +++++++++
 tb/tb_fixed_point_accumulator.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_accumulator.sv
// Accumulates NUM_TERMS sign-magnitude Q7.24 products into a 36-bit two's complement sum,
// then rounds and saturates the result to sign-magnitude Q3.12 on a valid/ready output.
module fixed_point_accumulator #(
  parameter int unsigned NUM_TERMS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_product,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, DONE} state_t;

  state_t      state, state_nxt;
  logic [35:0] acc;
  logic [4:0]  count;

  logic        beat;
  logic        last_beat;
  logic [35:0] term_mag;
  logic [35:0] term;

  logic [35:0] abs_acc;
  logic [24:0] rounded;
  logic        norm_sat;
  logic [14:0] norm_mag;
  logic        norm_sign;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  assign beat      = in_ready && in_valid;
  assign last_beat = beat && (count == 5'(NUM_TERMS - 1));

  // Negative zero (0x80000000) negates to zero, so it contributes nothing.
  assign term_mag = {5'b0, in_product[30:0]};
  assign term     = in_product[31] ? (~term_mag + 36'd1) : term_mag;

  // Round-half-away-from-zero is done on |acc| so it is symmetric about zero.
  assign abs_acc   = acc[35] ? (~acc + 36'd1) : acc;
  assign rounded   = {1'b0, abs_acc[35:12]} + {24'b0, abs_acc[11]};
  assign norm_sat  = (rounded > 25'h0007FFF);
  assign norm_mag  = norm_sat ? 15'h7FFF : rounded[14:0];
  assign norm_sign = acc[35] && (norm_mag != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: if (last_beat) state_nxt = NORM;
      NORM:  state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc   <= '0;
        count <= '0;
      end else if (beat) begin
        acc   <= acc + term;
        count <= count + 5'd1;
      end
      if (state == NORM) begin
        out_data <= {norm_sign, norm_mag};
        out_sat  <= norm_sat;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Scoreboard bench for fixed_point_accumulator (NUM_TERMS = 4): expected {sat, data}
// is queued as beats are driven and popped when the result appears.
module tb_fixed_point_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_product = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [16:0] sb [$];

  always #5 clk = ~clk;

  fixed_point_accumulator #(.NUM_TERMS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_product(in_product),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  // Reference: exact integer sum, then round |sum| / 4096 half away from zero.
  function automatic logic [16:0] model(input logic [31:0] p [4]);
    longint s = 0;
    longint a;
    longint r;
    logic sat;
    logic [14:0] mag;
    for (int i = 0; i < 4; i++) begin
      if (p[i][31]) s = s - longint'({33'b0, p[i][30:0]});
      else          s = s + longint'({33'b0, p[i][30:0]});
    end
    a = (s < 0) ? -s : s;
    r = (a + 2048) / 4096;
    sat = (r > 32767);
    mag = sat ? 15'h7FFF : r[14:0];
    return {sat, (s < 0) && (mag != 0), mag};
  endfunction

  // Runs one full transaction; hold > 0 keeps out_ready low that many cycles in DONE
  // while pulsing start/in_valid, which must be ignored.
  task automatic run_txn(input string tag, input logic [31:0] p [4], input logic [16:0] exp_v,
                         input int max_gap, input int hold);
    logic [16:0] e;
    logic [15:0] held;
    int waited;
    sb.push_back(exp_v);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s start->in_ready: in_ready=%b busy=%b required 1 1", tag, in_ready, busy);
    end
    for (int i = 0; i < 4; i++) begin
      if (max_gap > 0) begin
        int g = $urandom_range(max_gap, 0);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_product = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_product = p[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_product = 32'hDEADBEEF;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    e = sb.pop_front();
    checks++;
    if (waited != 1) begin
      failures++;
      $display("FAIL %s latency: out_valid after %0d extra cycles, required 1", tag, waited);
    end
    checks++;
    if ({out_sat, out_data} !== e) begin
      failures++;
      $display("FAIL %s result: sat=%b data=%h required sat=%b data=%h", tag, out_sat, out_data, e[16], e[15:0]);
    end
    held = out_data;
    for (int c = 0; c < hold; c++) begin
      start = 1'b1;
      in_valid = 1'b1;
      in_product = 32'h00400000;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held || out_sat !== e[16]) begin
        failures++;
        $display("FAIL %s hold%0d: valid=%b in_ready=%b data=%h sat=%b required 1 0 %h %b",
                 tag, c, out_valid, in_ready, out_data, out_sat, held, e[16]);
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: out_valid=%b busy=%b required 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy, out_sat, out_data} !== 20'h0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b sat=%b data=%h required all 0",
               in_ready, out_valid, busy, out_sat, out_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_start: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v [4];
    v = '{32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000};
    run_txn("basic", v, 17'h01000, 0, 0);
  endtask

  task automatic test_mixed();
    logic [31:0] v [4];
    v = '{32'h00800000, 32'h80400000, 32'h00400000, 32'h80000000};
    run_txn("mixed", v, 17'h00800, 0, 0);
    v = '{32'h00400000, 32'h80400000, 32'h00000000, 32'h00000000};
    run_txn("mixed_zero", v, 17'h00000, 0, 0);
  endtask

  task automatic test_rounding();
    logic [31:0] v [4];
    v = '{32'h00000800, 32'h0, 32'h0, 32'h0};
    run_txn("round_pos_half", v, 17'h00001, 0, 0);
    v = '{32'h80000800, 32'h0, 32'h0, 32'h0};
    run_txn("round_neg_half", v, 17'h08001, 0, 0);
    v = '{32'h000007FF, 32'h0, 32'h0, 32'h0};
    run_txn("round_below_half", v, 17'h00000, 0, 0);
  endtask

  task automatic test_saturation();
    logic [31:0] v [4];
    v = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
    run_txn("sat_pos", v, 17'h17FFF, 0, 0);
    v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_txn("sat_neg", v, 17'h1FFFF, 0, 0);
  endtask

  task automatic test_gaps();
    logic [31:0] v [4];
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 4; i++) v[i] = {$urandom_range(1, 0) == 1, 11'b0, 20'($urandom)} | (t > 3 ? 32'h01000000 : 32'h0);
      run_txn("gap_seq", v, model(v), 0, 0);
      run_txn("gap_rand", v, model(v), 4, 0);
    end
  endtask

  task automatic test_out_hold();
    logic [31:0] v [4];
    v = '{32'h00300000, 32'h80100000, 32'h00200000, 32'h00001800};
    run_txn("out_hold", v, model(v), 0, 3);
    v = '{32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000};
    run_txn("after_hold", v, 17'h01000, 0, 0);
  endtask

  task automatic test_midreset();
    logic [31:0] v [4];
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_product = 32'h05000000;
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy, out_sat, out_data} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_state: rdy=%b vld=%b busy=%b sat=%b data=%h required all 0",
               in_ready, out_valid, busy, out_sat, out_data);
    end
    v = '{32'h00400000, 32'h00400000, 32'h00400000, 32'h00400000};
    run_txn("after_reset", v, 17'h01000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_rounding();
    test_saturation();
    test_gaps();
    test_out_hold();
    test_midreset();
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
